// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage owning the PC, halt state and retired-instruction count
module pc_fetch_unit #(
  parameter logic [31:0] PC0   = 32'h00000000,
  parameter int          CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic [31:0]      iload,
  input  logic             pcEn,
  input  logic [1:0]       pcSel,
  input  logic [31:0]      ext32,
  input  logic [25:0]      immJ26,
  input  logic [31:0]      rdat1,
  input  logic             halt,
  output logic             imemREN,
  output logic [31:0]      imemaddr,
  output logic [31:0]      ins,
  output logic [31:0]      pc,
  output logic [31:0]      npc,
  output logic             halted,
  output logic             misalign,
  output logic [CNT_W-1:0] icount
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d, ins_q, ins_d, target;
  logic             misalign_q, misalign_d, run, upd, go_halt;
  logic [CNT_W-1:0] icount_q, icount_d;
  assign run      = state_q == RUN;
  assign upd      = run && pcEn && ihit && !halt;
  assign go_halt  = run && halt && ihit;
  assign npc      = pc_q + 32'd4;
  assign pc       = pc_q;
  assign imemaddr = pc_q;
  assign imemREN  = run;
  assign halted   = state_q == HALTED;
  assign misalign = misalign_q;
  assign icount   = icount_q;
  assign ins      = ihit ? iload : ins_q;
  // next-state: halt beats a PC update; HALTED only leaves through reset
  always_comb begin
    target     = pcSel == 2'd0 ? npc :
                 pcSel == 2'd1 ? npc + (ext32 << 2) :
                 pcSel == 2'd2 ? {npc[31:28], immJ26, 2'b00} : {rdat1[31:2], 2'b00};
    state_d    = go_halt ? HALTED : state_q;
    pc_d       = upd ? target : pc_q;
    ins_d      = run && ihit ? iload : ins_q;
    misalign_d = misalign_q | (upd && pcSel == 2'd3 && |rdat1[1:0]);
    icount_d   = icount_q + CNT_W'(upd | go_halt);
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= RUN;
      pc_q       <= PC0;
      ins_q      <= '0;
      misalign_q <= 1'b0;
      icount_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ins_q      <= ins_d;
      misalign_q <= misalign_d;
      icount_q   <= icount_d;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: vector table plus scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;
  logic        CLK = 1'b0, nRST = 1'b0, ihit = 1'b0, pcEn = 1'b0, halt = 1'b0;
  logic [31:0] iload = '0, ext32 = '0, rdat1 = '0;
  logic [1:0]  pcSel = 2'd0;
  logic [25:0] immJ26 = '0;
  logic        imemREN, halted, misalign;
  logic [31:0] imemaddr, ins, pc, npc, icount;

  pc_fetch_unit dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .pcEn(pcEn), .pcSel(pcSel),
    .ext32(ext32), .immJ26(immJ26), .rdat1(rdat1), .halt(halt), .imemREN(imemREN),
    .imemaddr(imemaddr), .ins(ins), .pc(pc), .npc(npc), .halted(halted),
    .misalign(misalign), .icount(icount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        en;
    logic [1:0]  sel;
    logic [31:0] ext;
    logic [25:0] imm;
    logic [31:0] rd;
    logic        hlt;
    logic        hit;
    logic [31:0] il;
    logic [31:0] exp_ins;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_mis;
    logic        exp_hlt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        mis;
    logic        hlt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [1:0] sel, input logic [31:0] ext,
                     input logic [25:0] imm, input logic [31:0] rd, input logic hlt,
                     input logic hit, input logic [31:0] il, input logic [31:0] ei,
                     input logic [31:0] ep, input logic [31:0] ec, input logic em,
                     input logic eh);
    vec_t v;
    v.en = en; v.sel = sel; v.ext = ext; v.imm = imm; v.rd = rd; v.hlt = hlt;
    v.hit = hit; v.il = il; v.exp_ins = ei; v.exp_pc = ep; v.exp_cnt = ec;
    v.exp_mis = em; v.exp_hlt = eh;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e, g;
    pcEn = v.en; pcSel = v.sel; ext32 = v.ext; immJ26 = v.imm; rdat1 = v.rd;
    halt = v.hlt; ihit = v.hit; iload = v.il;
    e.pc = v.exp_pc; e.cnt = v.exp_cnt; e.mis = v.exp_mis; e.hlt = v.exp_hlt;
    sb.push_back(e);
    #2;
    chk($sformatf("ins[%0d]", idx), ins, v.exp_ins);
    @(posedge CLK);
    #1;
    g = sb.pop_front();
    chk($sformatf("pc[%0d]", idx), pc, g.pc);
    chk($sformatf("imemaddr[%0d]", idx), imemaddr, g.pc);
    chk($sformatf("npc[%0d]", idx), npc, g.pc + 32'd4);
    chk($sformatf("icount[%0d]", idx), icount, g.cnt);
    chk($sformatf("misalign[%0d]", idx), {31'd0, misalign}, {31'd0, g.mis});
    chk($sformatf("halted[%0d]", idx), {31'd0, halted}, {31'd0, g.hlt});
    chk($sformatf("imemREN[%0d]", idx), {31'd0, imemREN}, {31'd0, !g.hlt});
  endtask

  initial begin
    //   en sel ext           imm        rd            hlt hit iload         ins           pc            cnt  mis hlt
    add(1, 0, 0,            0,         0,            0, 1, 32'h10000011, 32'h10000011, 32'h00000004, 1,  0, 0);
    add(1, 0, 0,            0,         0,            0, 1, 32'h10000012, 32'h10000012, 32'h00000008, 2,  0, 0);
    add(1, 0, 0,            0,         0,            0, 1, 32'h10000013, 32'h10000013, 32'h0000000C, 3,  0, 0);
    add(1, 3, 0,            0,         32'h100,      0, 1, 32'h10000014, 32'h10000014, 32'h00000100, 4,  0, 0);
    add(1, 1, 32'hFFFFFFFE, 0,         0,            0, 1, 32'h10000015, 32'h10000015, 32'h000000FC, 5,  0, 0);
    add(1, 1, 32'h3,        0,         0,            0, 1, 32'h10000016, 32'h10000016, 32'h0000010C, 6,  0, 0);
    add(1, 3, 0,            0,         32'h40000010, 0, 1, 32'h10000017, 32'h10000017, 32'h40000010, 7,  0, 0);
    add(1, 2, 0,            26'h123,   0,            0, 1, 32'h10000018, 32'h10000018, 32'h4000048C, 8,  0, 0);
    add(1, 3, 0,            0,         32'h2003,     0, 1, 32'h10000019, 32'h10000019, 32'h00002000, 9,  1, 0);
    add(1, 0, 0,            0,         0,            0, 1, 32'h1000001A, 32'h1000001A, 32'h00002004, 10, 1, 0);
    add(0, 0, 0,            0,         0,            0, 1, 32'h1000001B, 32'h1000001B, 32'h00002004, 10, 1, 0);
    for (int i = 0; i < 4; i++)
      add(1, 0, 0,          0,         0,            0, 0, 32'h10000021 + i, 32'h1000001B, 32'h00002004, 10, 1, 0);
    add(1, 0, 0,            0,         0,            1, 0, 32'h10000025, 32'h1000001B, 32'h00002004, 10, 1, 0);
    add(1, 3, 0,            0,         32'hFFFFFFFC, 0, 1, 32'h10000026, 32'h10000026, 32'hFFFFFFFC, 11, 1, 0);
    add(1, 0, 0,            0,         0,            0, 1, 32'h10000027, 32'h10000027, 32'h00000000, 12, 1, 0);
    add(1, 3, 0,            0,         32'h20,       0, 1, 32'h10000028, 32'h10000028, 32'h00000020, 13, 1, 0);
    add(1, 0, 0,            0,         0,            1, 1, 32'h10000029, 32'h10000029, 32'h00000020, 14, 1, 1);
    add(1, 0, 0,            0,         0,            0, 1, 32'h1000002A, 32'h1000002A, 32'h00000020, 14, 1, 1);
    add(1, 3, 0,            0,         32'h44,       0, 0, 32'h1000002B, 32'h10000029, 32'h00000020, 14, 1, 1);

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_npc", npc, 32'h4);
    chk("rst_icount", icount, 32'h0);
    chk("rst_ins", ins, 32'h0);
    chk("rst_flags", {29'd0, halted, misalign, imemREN}, 32'h1);
    nRST = 1'b1;
    foreach (vecs[i]) apply(vecs[i], i);

    #3;
    nRST = 1'b0;
    ihit = 1'b0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_icount", icount, 32'h0);
    chk("async_ins", ins, 32'h0);
    chk("async_flags", {29'd0, halted, misalign, imemREN}, 32'h1);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    vecs.delete();
    add(1, 0, 0, 0, 0, 0, 1, 32'h10000031, 32'h10000031, 32'h00000004, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 32'h10000032, 32'h10000032, 32'h00000008, 2, 0, 0);
    foreach (vecs[i]) apply(vecs[i], 100 + i);

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
